// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: walks the datapath through fetch/decode/execute/memory/writeback
// and gates PC, register-file and data-memory updates so each fires once per instruction.
module cpu_sequencer #(
  parameter int          PC_W      = 6,
  parameter int          ICNT_W    = 16,
  parameter int          MEM_WAIT  = 1,
  parameter logic [31:0] HALT_INST = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  input  logic              halt_req,
  input  logic [31:0]       inst,
  input  logic [PC_W-1:0]   pc,
  input  logic              dec_we1,
  input  logic              dec_we2,
  input  logic              dec_mux2,
  output logic              ir_load,
  output logic              pc_en,
  output logic              rf_we,
  output logic              dm_we,
  output logic [2:0]        state,
  output logic              busy,
  output logic              halted,
  output logic              pc_wrap,
  output logic [ICNT_W-1:0] inst_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DEC   = 3'd2;
  localparam logic [2:0] S_EXE   = 3'd3;
  localparam logic [2:0] S_MEM   = 3'd4;
  localparam logic [2:0] S_WB    = 3'd5;
  localparam logic [2:0] S_PAUSE = 3'd6;
  localparam logic [2:0] S_HALT  = 3'd7;

  localparam logic [3:0] WAIT_LD = 4'(MEM_WAIT - 1);

  logic [2:0] nxt;
  logic [3:0] wait_cnt;
  logic       at_wrap;

  assign at_wrap = (pc == {PC_W{1'b1}});

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start) nxt = S_FETCH;
      S_FETCH: nxt = S_DEC;
      S_DEC:   nxt = (inst == HALT_INST) ? S_HALT : S_EXE;
      S_EXE:   nxt = (dec_we2 || !dec_mux2) ? S_MEM : S_WB;
      S_MEM:   if (wait_cnt == 4'd0) nxt = S_WB;
      S_WB: begin
        if (at_wrap)        nxt = S_HALT;
        else if (halt_req)  nxt = S_HALT;
        else if (step_mode) nxt = S_PAUSE;
        else                nxt = S_FETCH;
      end
      S_PAUSE: begin
        if (halt_req)                nxt = S_HALT;
        else if (step || !step_mode) nxt = S_FETCH;
      end
      S_HALT:  if (start) nxt = S_FETCH;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      wait_cnt   <= 4'd0;
      inst_count <= '0;
      pc_wrap    <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_EXE && nxt == S_MEM)
        wait_cnt <= WAIT_LD;
      else if (state == S_MEM && wait_cnt != 4'd0)
        wait_cnt <= wait_cnt - 4'd1;
      if (state == S_WB && inst_count != {ICNT_W{1'b1}})
        inst_count <= inst_count + 1'b1;
      // Sticky until the harness restarts from HALT.
      if (state == S_WB && at_wrap)
        pc_wrap <= 1'b1;
      else if (state == S_HALT && start)
        pc_wrap <= 1'b0;
    end
  end

  // Moore decode; reset forces state to IDLE so every enable drops immediately.
  assign ir_load = (state == S_FETCH);
  assign dm_we   = (state == S_MEM) && (wait_cnt == 4'd0) && dec_we2;
  assign rf_we   = (state == S_WB) && dec_we1;
  assign pc_en   = (state == S_WB);
  assign busy    = (state >= S_FETCH) && (state <= S_WB);
  assign halted  = (state == S_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: main instance with MEM_WAIT=3, second with MEM_WAIT=1.
module tb_cpu_sequencer;
  logic        clk = 1'b0;
  logic        reset, start, step_mode, step, halt_req;
  logic [31:0] inst;
  logic [5:0]  pc;
  logic        dec_we1, dec_we2, dec_mux2;

  logic        ir_load, pc_en, rf_we, dm_we, busy, halted, pc_wrap;
  logic [2:0]  state;
  logic [15:0] inst_count;
  logic        d1_ir_load, d1_pc_en, d1_rf_we, d1_dm_we, d1_busy, d1_halted, d1_pc_wrap;
  logic [2:0]  d1_state;
  logic [15:0] d1_inst_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.PC_W(6), .ICNT_W(16), .MEM_WAIT(3)) u_dut (
    .clk(clk), .reset(reset), .start(start), .step_mode(step_mode), .step(step),
    .halt_req(halt_req), .inst(inst), .pc(pc), .dec_we1(dec_we1), .dec_we2(dec_we2),
    .dec_mux2(dec_mux2), .ir_load(ir_load), .pc_en(pc_en), .rf_we(rf_we), .dm_we(dm_we),
    .state(state), .busy(busy), .halted(halted), .pc_wrap(pc_wrap), .inst_count(inst_count));

  cpu_sequencer #(.PC_W(6), .ICNT_W(16), .MEM_WAIT(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .step_mode(step_mode), .step(step),
    .halt_req(halt_req), .inst(inst), .pc(pc), .dec_we1(dec_we1), .dec_we2(dec_we2),
    .dec_mux2(dec_mux2), .ir_load(d1_ir_load), .pc_en(d1_pc_en), .rf_we(d1_rf_we),
    .dm_we(d1_dm_we), .state(d1_state), .busy(d1_busy), .halted(d1_halted),
    .pc_wrap(d1_pc_wrap), .inst_count(d1_inst_count));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic we1, input logic we2, input logic mux2);
    dec_we1 = we1; dec_we2 = we2; dec_mux2 = mux2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0; halt_req = 1'b0;
    inst = 32'h0000_0013; pc = 6'd0;
    set_op(1'b1, 1'b0, 1'b1);
    tick(); tick();
    chk("rst_state", state, 0); chk("rst_busy", busy, 0); chk("rst_cnt", inst_count, 0);
    chk("rst_wrap", pc_wrap, 0); chk("rst_halted", halted, 0);
    reset = 1'b0;
    tick();
    chk("idle_hold", state, 0);

    // ALU instruction: 1,2,3,5,1
    start = 1'b1; tick(); start = 1'b0;
    chk("alu_f", state, 1); chk("alu_irld", ir_load, 1); chk("alu_busy", busy, 1);
    tick(); chk("alu_d", state, 2); chk("alu_d_pcen", pc_en, 0);
    tick(); chk("alu_e", state, 3); chk("alu_e_rfwe", rf_we, 0);
    tick(); chk("alu_wb", state, 5); chk("alu_wb_rfwe", rf_we, 1); chk("alu_wb_pcen", pc_en, 1);
    tick(); chk("alu_f2", state, 1); chk("alu_cnt", inst_count, 1); chk("alu_f2_pcen", pc_en, 0);

    // Load, MEM_WAIT=3: 7 cycles FETCH to FETCH
    set_op(1'b1, 1'b0, 1'b0);
    tick(); chk("ld_d", state, 2);
    tick(); chk("ld_e", state, 3);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("ld_m", state, 4); chk("ld_m_dmwe", dm_we, 0); chk("ld_m_rfwe", rf_we, 0);
    end
    tick(); chk("ld_wb", state, 5); chk("ld_wb_rfwe", rf_we, 1);
    tick(); chk("ld_f", state, 1); chk("ld_cnt", inst_count, 2);

    // Store on the MEM_WAIT=3 instance: dm_we only in the final MEMORY cycle
    set_op(1'b0, 1'b1, 1'b1);
    tick(); tick(); chk("st3_e", state, 3);
    tick(); chk("st3_m0", dm_we, 0);
    tick(); chk("st3_m1", dm_we, 0);
    tick(); chk("st3_m2", dm_we, 1); chk("st3_m2_st", state, 4);
    tick(); chk("st3_wb", state, 5); chk("st3_wb_rfwe", rf_we, 0); chk("st3_wb_dmwe", dm_we, 0);
    tick(); chk("st3_f", state, 1); chk("st3_cnt", inst_count, 3);

    // Halt instruction
    inst = 32'hFFFF_FFFF; set_op(1'b1, 1'b0, 1'b1);
    tick(); chk("hi_d", state, 2); chk("hi_d_pcen", pc_en, 0);
    tick(); chk("hi_halt", state, 7); chk("hi_halted", halted, 1); chk("hi_pcen", pc_en, 0);
    chk("hi_busy", busy, 0);
    tick(); chk("hi_hold", state, 7); chk("hi_cnt", inst_count, 3);
    inst = 32'h0000_0013;
    start = 1'b1; tick(); start = 1'b0;
    chk("hi_restart", state, 1);

    // Single-step over 3 instructions
    step_mode = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick(); tick(); tick(); chk("ss_wb", state, 5);
      tick(); chk("ss_pause", state, 6); chk("ss_cnt", inst_count, 32'(4 + n));
      tick(); chk("ss_pause_hold", state, 6);
      if (n < 2) begin
        step = 1'b1; tick(); step = 1'b0;
        chk("ss_fetch", state, 1);
      end else begin
        step = 1'b1; halt_req = 1'b1; tick(); step = 1'b0; halt_req = 1'b0;
        chk("ss_halt", state, 7);
      end
    end
    step_mode = 1'b0;

    // PC wrap
    pc = 6'd63;
    start = 1'b1; tick(); start = 1'b0;
    chk("wr_f", state, 1); chk("wr_f_flag", pc_wrap, 0);
    tick(); tick(); tick(); chk("wr_wb", state, 5);
    tick(); chk("wr_halt", state, 7); chk("wr_flag", pc_wrap, 1); chk("wr_cnt", inst_count, 7);
    pc = 6'd0;
    start = 1'b1; tick(); start = 1'b0;
    chk("wr_restart", state, 1); chk("wr_clear", pc_wrap, 0);

    // Reset mid-MEMORY while a store is about to write
    set_op(1'b0, 1'b1, 1'b1);
    tick(); tick(); tick(); tick(); tick();
    chk("rm_m2", state, 4); chk("rm_m2_dmwe", dm_we, 1);
    #2 reset = 1'b1;
    #1 chk("rm_state", state, 0); chk("rm_dmwe", dm_we, 0); chk("rm_cnt", inst_count, 0);
    chk("rm_wrap", pc_wrap, 0);
    #1 reset = 1'b0;

    // Store on the MEM_WAIT=1 instance
    start = 1'b1; tick(); start = 1'b0;
    chk("st1_f", d1_state, 1);
    tick(); chk("st1_d", d1_state, 2);
    tick(); chk("st1_e", d1_state, 3); chk("st1_e_dmwe", d1_dm_we, 0);
    tick(); chk("st1_m", d1_state, 4); chk("st1_m_dmwe", d1_dm_we, 1);
    tick(); chk("st1_wb", d1_state, 5); chk("st1_wb_dmwe", d1_dm_we, 0); chk("st1_wb_rfwe", d1_rf_we, 0);
    tick(); chk("st1_f2", d1_state, 1); chk("st1_cnt", d1_inst_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
